// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the OR-bus arbiter: bus data width, FSM state
// encodings and a small helper that sizes requester index fields.
package data_bus_arbiter_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN  = 2'd1,
    ARB_TURN = 2'd2
  } arb_state_t;

  // Width of a requester index; never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Request/data/grant bundle between the requesters (master) and the
// arbiter (slave). req_data slice i belongs to requester i.
interface data_bus_arbiter_if #(
  parameter int N_REQ = 4
) ();
  import data_bus_arbiter_pkg::*;

  logic [N_REQ-1:0]            req;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            grant;
  logic [DATA_WIDTH-1:0]       bus_data;
  logic                        bus_valid;

  modport master (
    output req, req_data,
    input  grant, bus_data, bus_valid
  );

  modport slave (
    input  req, req_data,
    output grant, bus_data, bus_valid
  );

endinterface

// File: rtl/data_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. The search starts at the
// requester after last_owner and wraps, so last_owner itself is checked last.
module rr_pick
  import data_bus_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [N_REQ-1:0] winner,
  output logic             any
);

  logic [IDX_W:0]   start;
  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] first;

  // Rotate the search origin to bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    start  = {1'b0, last_owner} + (IDX_W+1)'(1);
    rot    = N_REQ'({req, req} >> start);
    first  = rot & (~rot + N_REQ'(1));
    winner = N_REQ'(({first, first} << start) >> N_REQ);
    any    = |req;
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: round-robin owner selection for an OR-combined data bus
// with a per-owner burst limit.
// Build option: define DATA_BUS_ARB_TURNAROUND_EN to insert one idle bus
// cycle (grant=0) after every release; otherwise ownership hands over
// directly at the release edge.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ARB_IDLE | no owner, arbitrate every cycle
//   ARB_OWN  | one owner holds grant, burst counter running
//   ARB_TURN | one dead cycle between owners (turnaround build)
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  data_bus_arbiter_if.slave bus
);

  localparam int               IDX_W      = idx_width(N_REQ);
  localparam logic [7:0]       BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(N_REQ - 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [7:0]       burst_q, burst_d;
  logic [IDX_W-1:0] last_q, last_d;

  logic [IDX_W-1:0] owner_idx;
  logic [IDX_W-1:0] pick_base;
  logic [N_REQ-1:0] pick_win;
  logic             pick_any;
  logic             owner_req;
  logic             expire;

  logic [IDX_W-1:0]      idx_or  [N_REQ+1];
  logic [DATA_WIDTH-1:0] data_or [N_REQ+1];

  assign idx_or[0]  = '0;
  assign data_or[0] = '0;

  // grant is one-hot, so OR-ing the masked terms recovers the owner index
  // and the owner's data without letting other slices (even X) through.
  for (genvar g = 0; g < N_REQ; g++) begin : g_bus
    assign idx_or[g+1]  = idx_or[g] | (grant_q[g] ? IDX_W'(g) : '0);
    assign data_or[g+1] = data_or[g] |
                          (bus.req_data[g*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[g]}});
  end

  assign owner_idx     = idx_or[N_REQ];
  assign owner_req     = |(bus.req & grant_q);
  assign expire        = (burst_q == BURST_LAST);
  assign bus.grant     = grant_q;
  assign bus.bus_data  = data_or[N_REQ];
  assign bus.bus_valid = |grant_q;

  // While owning, search from the current owner so it ends up last in line.
  assign pick_base = (state_q == ARB_OWN) ? owner_idx : last_q;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req        (bus.req),
    .last_owner (pick_base),
    .winner     (pick_win),
    .any        (pick_any)
  );

  // Next state, grant, burst count and last owner.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    burst_d = burst_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE, ARB_TURN: begin
        burst_d = '0;
        if (pick_any) begin
          grant_d = pick_win;
          state_d = ARB_OWN;
        end else begin
          grant_d = '0;
          state_d = ARB_IDLE;
        end
      end
      ARB_OWN: begin
        if (owner_req && !expire) begin
          burst_d = burst_q + 8'd1;
        end else begin
          last_d  = owner_idx;
          burst_d = '0;
`ifdef DATA_BUS_ARB_TURNAROUND_EN
          grant_d = '0;
          state_d = ARB_TURN;
`else
          if (pick_any) begin
            grant_d = pick_win;
            state_d = ARB_OWN;
          end else begin
            grant_d = '0;
            state_d = ARB_IDLE;
          end
`endif
        end
      end
      default: begin
        grant_d = '0;
        burst_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State registers; reset drops grant immediately, even mid-burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      burst_q <= '0;
      last_q  <= LAST_INIT;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: reference model feeds a scoreboard queue at
// drive time; a monitor pops and compares one entry per clock. Directed
// tasks add their own inline checks on the grant sequence.
module tb_data_bus_arbiter;
  import data_bus_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int MAXB = 8;
  localparam int DW   = DATA_WIDTH;
  localparam logic [N-1:0] ONE = N'(1);

  typedef struct packed {
    logic [N-1:0]  grant;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  data_bus_arbiter_if #(.N_REQ(N)) bus_if ();

  data_bus_arbiter #(
    .N_REQ     (N),
    .MAX_BURST (MAXB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t mon_e;

  int m_owner = -1;
  int m_held  = 0;
  int m_last  = N - 1;

  // Reference model: held counts cycles of ownership, 1..MAXB.
  task automatic model_edge(input logic r_rst, input logic [N-1:0] r, output logic [N-1:0] g);
    g = '0;
    if (r_rst) begin
      m_owner = -1;
      m_held  = 0;
      m_last  = N - 1;
      return;
    end
    if (m_owner >= 0) begin
      if (((r & (ONE << m_owner)) != '0) && (m_held < MAXB)) begin
        m_held++;
        g = ONE << m_owner;
        return;
      end
      m_last  = m_owner;
      m_owner = -1;
      m_held  = 0;
`ifdef DATA_BUS_ARB_TURNAROUND_EN
      return;
`endif
    end
    for (int off = 1; off <= N; off++) begin
      int c;
      c = (m_last + off) % N;
      if ((r & (ONE << c)) != '0) begin
        m_owner = c;
        m_held  = 1;
        g = ONE << c;
        break;
      end
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [N-1:0] g, input logic [N*DW-1:0] d);
    logic [N*DW-1:0] sh;
    exp_data = '0;
    for (int i = 0; i < N; i++) begin
      if ((g & (ONE << i)) != '0) begin
        sh = d >> (i * DW);
        exp_data = sh[DW-1:0];
      end
    end
  endfunction

  // Requesting slices get nonzero random data, idle slices are X.
  task automatic drive(input logic [N-1:0] r);
    logic [N*DW-1:0] d;
    logic [DW-1:0]   s;
    d = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if ((r & (ONE << i)) != '0) s = DW'($urandom_range(1, 255));
      else                        s = 'x;
      d = {d[N*DW-DW-1:0], s};
    end
    bus_if.req      = r;
    bus_if.req_data = d;
  endtask

  task automatic tick();
    exp_t e;
    model_edge(rst, bus_if.req, e.grant);
    e.data = exp_data(e.grant, bus_if.req_data);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard consumer, sampling 1 time unit after each edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      total++;
      if (bus_if.grant !== mon_e.grant) begin
        bad++;
        $display("FAIL sb_grant t=%0t got=%b exp=%b", $time, bus_if.grant, mon_e.grant);
      end
      total++;
      if (!$onehot0(bus_if.grant)) begin
        bad++;
        $display("FAIL onehot0 t=%0t got=%b exp=at_most_one_bit", $time, bus_if.grant);
      end
      total++;
      if (bus_if.bus_valid !== (|mon_e.grant)) begin
        bad++;
        $display("FAIL sb_valid t=%0t got=%b exp=%b", $time, bus_if.bus_valid, |mon_e.grant);
      end
      total++;
      if (bus_if.bus_data !== mon_e.data) begin
        bad++;
        $display("FAIL sb_data t=%0t got=%h exp=%h", $time, bus_if.bus_data, mon_e.data);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    drive('0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(4'b1111);
    tick();
    tick();
    total++;
    if (bus_if.grant !== 4'b0000) begin
      bad++; $display("FAIL reset_grant got=%b exp=0000", bus_if.grant);
    end
    total++;
    if (bus_if.bus_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b exp=0", bus_if.bus_valid);
    end
    total++;
    if (bus_if.bus_data !== '0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", bus_if.bus_data);
    end
    rst = 1'b0;
    drive('0);
    tick();
    total++;
    if (bus_if.grant !== 4'b0000) begin
      bad++; $display("FAIL idle_grant got=%b exp=0000", bus_if.grant);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] d0;
    do_reset();
    drive(4'b0001);
    d0 = bus_if.req_data[DW-1:0];
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++;
      if (bus_if.grant !== 4'b0001) begin
        bad++; $display("FAIL single_grant k=%0d got=%b exp=0001", k, bus_if.grant);
      end
      total++;
      if (bus_if.bus_data !== d0) begin
        bad++; $display("FAIL single_data k=%0d got=%h exp=%h", k, bus_if.bus_data, d0);
      end
    end
    drive('0);
    tick();
    total++;
    if (bus_if.grant !== 4'b0000) begin
      bad++; $display("FAIL single_release got=%b exp=0000", bus_if.grant);
    end
  endtask

  task automatic test_all_req();
    logic [N-1:0] exp_g;
    do_reset();
    drive(4'b1111);
    for (int k = 1; k <= 36; k++) begin
      tick();
`ifdef DATA_BUS_ARB_TURNAROUND_EN
      exp_g = (((k - 1) % 9) == 8) ? 4'b0000 : (ONE << (((k - 1) / 9) % N));
`else
      exp_g = ONE << (((k - 1) / MAXB) % N);
`endif
      total++;
      if (bus_if.grant !== exp_g) begin
        bad++; $display("FAIL all_req k=%0d got=%b exp=%b", k, bus_if.grant, exp_g);
      end
    end
    drive('0);
    tick();
  endtask

  task automatic test_expiry();
    logic [N-1:0]  exp_g;
    logic [DW-1:0] d2;
    do_reset();
    drive(4'b0100);
    d2 = bus_if.req_data[2*DW +: DW];
    for (int k = 1; k <= 20; k++) begin
      tick();
`ifdef DATA_BUS_ARB_TURNAROUND_EN
      exp_g = (((k - 1) % 9) == 8) ? 4'b0000 : 4'b0100;
`else
      exp_g = 4'b0100;
`endif
      total++;
      if (bus_if.grant !== exp_g) begin
        bad++; $display("FAIL expiry_grant k=%0d got=%b exp=%b", k, bus_if.grant, exp_g);
      end
      total++;
      if (bus_if.bus_data !== ((exp_g == '0) ? '0 : d2)) begin
        bad++; $display("FAIL expiry_data k=%0d got=%h exp=%h", k, bus_if.bus_data,
                        (exp_g == '0) ? '0 : d2);
      end
    end
    drive('0);
    tick();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive(4'b0100);
    for (int k = 1; k <= 4; k++) tick();
    rst = 1'b1;
    tick();
    total++;
    if (bus_if.grant !== 4'b0000) begin
      bad++; $display("FAIL midrst_grant got=%b exp=0000", bus_if.grant);
    end
    total++;
    if (bus_if.bus_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_valid got=%b exp=0", bus_if.bus_valid);
    end
    rst = 1'b0;
    drive(4'b0110);
    tick();
    total++;
    if (bus_if.grant !== 4'b0010) begin
      bad++; $display("FAIL midrst_first got=%b exp=0010", bus_if.grant);
    end
    drive('0);
    tick();
    tick();
  endtask

  task automatic test_pending();
    do_reset();
    drive(4'b0001);
    tick();
    total++;
    if (bus_if.grant !== 4'b0001) begin
      bad++; $display("FAIL pend_start got=%b exp=0001", bus_if.grant);
    end
    drive(4'b1011);
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++;
      if (bus_if.grant !== 4'b0001) begin
        bad++; $display("FAIL pend_hold k=%0d got=%b exp=0001", k, bus_if.grant);
      end
    end
    drive(4'b1010);
    tick();
`ifdef DATA_BUS_ARB_TURNAROUND_EN
    total++;
    if (bus_if.grant !== 4'b0000) begin
      bad++; $display("FAIL pend_gap got=%b exp=0000", bus_if.grant);
    end
    tick();
`endif
    total++;
    if (bus_if.grant !== 4'b0010) begin
      bad++; $display("FAIL pend_next got=%b exp=0010", bus_if.grant);
    end
    drive('0);
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    do_reset();
    r = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) r = r ^ (ONE << i);
      end
      drive(r);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_expiry();
    test_reset_mid_burst();
    test_pending();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout t=%0t got=running exp=finished", $time);
    $fatal(1, "timeout");
  end

endmodule
